// File: rtl/alu_issue_ctrl.sv
// Issue/write-back controller around an external 32-bit combinational ALU with an 8-entry register file.
// Optional `MUL_WAIT_EN: opcode 100 (mul) gets a second EXEC cycle before the result is captured.
module alu_issue_ctrl #(
  parameter int unsigned NREGS = 8,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ins_valid,
  output logic                     ins_ready,
  input  logic [15:0]              ins_word,
  output logic [2:0]               alu_op,
  output logic [DW-1:0]            alu_a,
  output logic [DW-1:0]            alu_b,
  input  logic [DW-1:0]            alu_r,
  input  logic                     alu_z,
  input  logic                     host_we,
  input  logic [$clog2(NREGS)-1:0] host_addr,
  input  logic [DW-1:0]            host_wdata,
  output logic [DW-1:0]            host_rdata,
  output logic                     done,
  output logic                     zero,
  output logic                     busy
);

  localparam int unsigned AW = $clog2(NREGS);
  localparam logic [2:0]  OP_MUL = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_EXEC2,
    S_WB
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_accept;
  logic            w_load;
  logic            w_capture;
  logic            w_wb;
  logic [2:0]      r_op;
  logic [AW-1:0]   r_rd;
  logic [AW-1:0]   r_rs1;
  logic [AW-1:0]   r_rs2;
  logic [DW-1:0]   r_result;
  logic [DW-1:0]   r_regs [NREGS];
  logic            w_unused_ins;

  assign w_unused_ins = ^ins_word[3:0];

  assign ins_ready  = (r_state == S_IDLE) && !rst;
  assign host_rdata = r_regs[host_addr];

  // Next-state and per-state strobes.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_load    = 1'b0;
    w_capture = 1'b0;
    w_wb      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ins_valid && ins_ready) begin
          w_accept = 1'b1;
          w_next   = S_READ;
        end
      end
      S_READ: begin
        w_load = 1'b1;
        w_next = S_EXEC;
      end
      S_EXEC: begin
`ifdef MUL_WAIT_EN
        if (r_op == OP_MUL) begin
          w_next = S_EXEC2;
        end else begin
          w_capture = 1'b1;
          w_next    = S_WB;
        end
`else
        w_capture = 1'b1;
        w_next    = S_WB;
`endif
      end
      S_EXEC2: begin
        w_capture = 1'b1;
        w_next    = S_WB;
      end
      S_WB: begin
        w_wb   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, instruction latch, ALU drive and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_rd     <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_result <= '0;
      alu_op   <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      zero     <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      r_state <= w_next;
      done    <= (w_next == S_WB);
      busy    <= (w_next != S_IDLE);
      if (w_accept) begin
        r_op  <= ins_word[15:13];
        r_rd  <= AW'(ins_word[12:10]);
        r_rs1 <= AW'(ins_word[9:7]);
        r_rs2 <= AW'(ins_word[6:4]);
      end
      if (w_load) begin
        alu_op <= r_op;
        alu_a  <= r_regs[r_rs1];
        alu_b  <= r_regs[r_rs2];
      end
      if (w_capture) begin
        r_result <= alu_r;
        zero     <= alu_z;
      end
    end
  end

  // Register file; entry 0 is never written. Write-back is last so it wins over a host write to rd.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (host_we && (host_addr != '0)) begin
        r_regs[host_addr] <= host_wdata;
      end
      if (w_wb && (r_rd != '0)) begin
        r_regs[r_rd] <= r_result;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU; directed vectors with hand-computed results.
module tb_alu_issue_ctrl;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ins_valid = 1'b0;
  logic        ins_ready;
  logic [15:0] ins_word = 16'h0;
  logic [2:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_r;
  logic        alu_z;
  logic        host_we = 1'b0;
  logic [2:0]  host_addr = 3'd0;
  logic [31:0] host_wdata = 32'd0;
  logic [31:0] host_rdata;
  logic        done, zero, busy;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        z;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_seen = 0;
  int exp_done = 0;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_word(ins_word),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r), .alu_z(alu_z),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .done(done), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: unsigned set-less-than, unused opcodes return 0.
  always_comb begin
    case (alu_op)
      OP_ADD:  alu_r = alu_a + alu_b;
      OP_AND:  alu_r = alu_a & alu_b;
      OP_OR:   alu_r = alu_a | alu_b;
      OP_MUL:  alu_r = alu_a * alu_b;
      OP_SUB:  alu_r = alu_a - alu_b;
      OP_SLT:  alu_r = (alu_a < alu_b) ? 32'd1 : 32'd0;
      default: alu_r = 32'd0;
    endcase
    alu_z = (alu_r == 32'd0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_seen++;
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        m_e = q.pop_front();
        chk("done_cycle", 32'(cyc), 32'(m_e.cyc));
        chk("alu_op", 32'(alu_op), 32'(m_e.op));
        chk("alu_a", alu_a, m_e.a);
        chk("alu_b", alu_b, m_e.b);
        chk("zero", 32'(zero), 32'(m_e.z));
      end
    end
  end

  function automatic exp_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] r, input int c);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.z = (r == 32'd0); e.cyc = c;
`ifdef MUL_WAIT_EN
    if (op == OP_MUL) e.cyc = c + 1;
`endif
    return e;
  endfunction

  task automatic host_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk); host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk); host_we = 1'b0;
  endtask

  task automatic chk_reg(input string name, input logic [2:0] a, input logic [31:0] exp);
    @(negedge clk); host_addr = a; #1;
    chk(name, host_rdata, exp);
  endtask

  // Presents one instruction; returns at the negedge of its READ cycle.
  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input bit push);
    int c;
    @(negedge clk); ins_valid = 1'b1; ins_word = {op, rd, rs1, rs2, 4'h5};
    c = 0;
    while (!ins_ready && c < 20) begin @(negedge clk); c++; end
    if (!ins_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      ins_valid = 1'b0;
      return;
    end
    if (push) begin q.push_back(mk(op, a, b, r, cyc + 3)); exp_done++; end
    @(posedge clk); @(negedge clk); ins_valid = 1'b0; ins_word = 16'hFFFF;
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (q.size() != 0 && c < 30) begin @(negedge clk); c++; end
    if (q.size() != 0) chk("done_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic run(input string name, input logic [2:0] op, input logic [2:0] rd,
                     input logic [2:0] rs1, input logic [2:0] rs2,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] r);
    issue(op, rd, rs1, rs2, a, b, r, 1'b1);
    wait_done();
    chk_reg(name, rd, (rd == 3'd0) ? 32'd0 : r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bw [3];
    exp_t        be [3];
    int          acc [3];
    int          k, lows;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(ins_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    for (int i = 0; i < 8; i++) chk_reg("rst_reg", 3'(i), 32'd0);

    host_wr(3'd1, 32'd5);
    host_wr(3'd2, 32'd7);
    host_wr(3'd0, 32'd123);
    chk_reg("r0_host_write", 3'd0, 32'd0);
    run("add_r3", OP_ADD, 3'd3, 3'd1, 3'd2, 32'd5, 32'd7, 32'd12);
    run("sub_r4", OP_SUB, 3'd4, 3'd1, 3'd1, 32'd5, 32'd5, 32'd0);
    run("or_r4", OP_OR, 3'd4, 3'd1, 3'd2, 32'd5, 32'd7, 32'd7);
    run("add_r0", OP_ADD, 3'd0, 3'd1, 3'd2, 32'd5, 32'd7, 32'd12);
    run("slt_r6", OP_SLT, 3'd6, 3'd1, 3'd2, 32'd5, 32'd7, 32'd1);
    run("nop_r6", OP_NOP, 3'd6, 3'd1, 3'd2, 32'd5, 32'd7, 32'd0);
    host_wr(3'd7, 32'hFFFF_FFFF);
    host_wr(3'd5, 32'd9);
    run("slt_unsigned_r5", OP_SLT, 3'd5, 3'd7, 3'd1, 32'hFFFF_FFFF, 32'd5, 32'd0);

    // Back-to-back with ins_valid held high; junk word whenever not ready.
    bw[0] = {OP_AND, 3'd5, 3'd7, 3'd2, 4'h0};
    bw[1] = {OP_SUB, 3'd6, 3'd5, 3'd1, 4'h0};
    bw[2] = {OP_ADD, 3'd1, 3'd1, 3'd6, 4'h0};
    be[0] = mk(OP_AND, 32'hFFFF_FFFF, 32'd7, 32'd7, 0);
    be[1] = mk(OP_SUB, 32'd7, 32'd5, 32'd2, 0);
    be[2] = mk(OP_ADD, 32'd5, 32'd2, 32'd7, 0);
    k = 0; lows = 0;
    @(negedge clk); ins_valid = 1'b1;
    for (int c = 0; c < 40 && k < 3; c++) begin
      if (c > 0) @(negedge clk);
      if (ins_ready) begin
        ins_word = bw[k];
        be[k].cyc = cyc + 3;
        q.push_back(be[k]); exp_done++;
        acc[k] = cyc + 1;
        k++;
      end else begin
        ins_word = 16'hFFFF;
        if (k > 0) begin lows++; chk("busy_when_not_ready", 32'(busy), 32'd1); end
      end
    end
    @(posedge clk); @(negedge clk); ins_valid = 1'b0;
    chk("burst_accepts", 32'(k), 32'd3);
    chk("burst_gap01", 32'(acc[1] - acc[0]), 32'd4);
    chk("burst_gap12", 32'(acc[2] - acc[1]), 32'd4);
    chk("burst_not_ready", 32'(lows), 32'd6);
    wait_done();
    chk_reg("burst_r5", 3'd5, 32'd7);
    chk_reg("burst_r6", 3'd6, 32'd2);
    chk_reg("burst_r1", 3'd1, 32'd7);

    // Host write to rs1 in READ sees old operand; host write to rd in WB loses.
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, 32'd7, 32'd7, 32'd14, 1'b1);
    host_we = 1'b1; host_addr = 3'd1; host_wdata = 32'd99;
    @(negedge clk); host_we = 1'b0;
    @(negedge clk); host_we = 1'b1; host_addr = 3'd3; host_wdata = 32'hDEAD;
    @(negedge clk); host_we = 1'b0;
    wait_done();
    chk_reg("wb_beats_host", 3'd3, 32'd14);
    chk_reg("host_rs1_written", 3'd1, 32'd99);

    host_wr(3'd1, 32'd3);
    host_wr(3'd2, 32'd4);
    run("mul_r5", OP_MUL, 3'd5, 3'd1, 3'd2, 32'd3, 32'd4, 32'd12);
    run("sub_zero_r4", OP_SUB, 3'd4, 3'd1, 3'd1, 32'd3, 32'd3, 32'd0);

    // Reset during EXEC aborts the instruction.
    issue(OP_ADD, 3'd5, 3'd1, 3'd2, 32'd3, 32'd4, 32'd7, 1'b0);
    @(negedge clk); rst = 1'b1; #1;
    chk("abort_ready_in_rst", 32'(ins_ready), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("abort_ready_in_rst2", 32'(ins_ready), 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_ready", 32'(ins_ready), 32'd1);
    chk("abort_zero", 32'(zero), 32'd0);
    chk("abort_alu_op", 32'(alu_op), 32'd0);
    chk("abort_alu_a", alu_a, 32'd0);
    chk_reg("abort_r5", 3'd5, 32'd0);
    chk_reg("abort_r3", 3'd3, 32'd0);
    chk("done_count", 32'(done_seen), 32'(exp_done));
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
